// File: rtl/common_pseudo_lru_way_allocator.sv
// Way-allocation controller feeding a pseudo-LRU one-hot pick tree.
// Tracks per-way valid bits, picks a victim (lowest invalid way first,
// otherwise the PLRU pick), holds the grant through the fill, commits the
// way as valid with an LRU touch, and forwards lookup-hit touches.
`timescale 1ns/1ps

module common_pseudo_lru_way_allocator #(
  parameter int SUBJECT_COUNT_LOG2 = 1,
  localparam int P = 1 << SUBJECT_COUNT_LOG2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hit_valid,
  input  logic [P-1:0] hit_way,
  input  logic         inv_valid,
  input  logic [P-1:0] inv_way,
  input  logic         alloc_req_valid,
  output logic         alloc_req_ready,
  output logic         alloc_gnt_valid,
  output logic [P-1:0] alloc_gnt_way,
  input  logic         alloc_done,
  input  logic         alloc_abort,
  output logic [P-1:0] way_valid,
  output logic [P-1:0] lru_waddr,
  output logic         lru_wen,
  output logic [P-1:0] lru_dvalid,
  input  logic [P-1:0] lru_qaddr
);

  localparam logic [P-1:0] ONE_P = {{(P-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PICK,
    ST_FILL,
    ST_COMMIT
  } state_t;

  state_t       state;
  logic [P-1:0] victim_q;
  logic [P-1:0] way_valid_q;
  logic [P-1:0] gnt_way_q;
  logic         ready_q;
  logic         gnt_valid_q;
  logic         commit_q;

  logic [P-1:0] free_way;
  logic [P-1:0] pick_way;
  logic [P-1:0] inv_mask;
  logic [P-1:0] commit_mask;

  // Victim selection and the masks applied to the valid bits this cycle.
  always_comb begin
    // Lowest zero bit of way_valid: the increment carries through the
    // trailing ones and lands on the first zero.
    free_way    = ~way_valid_q & (way_valid_q + ONE_P);
    pick_way    = (&way_valid_q) ? lru_qaddr : free_way;
    inv_mask    = inv_valid ? inv_way : '0;
    commit_mask = commit_q ? victim_q : '0;
  end

  // Allocation state machine, valid-bit tracking and registered handshakes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      victim_q    <= '0;
      way_valid_q <= '0;
      gnt_way_q   <= '0;
      ready_q     <= 1'b1;
      gnt_valid_q <= 1'b0;
      commit_q    <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all of them see the same
      // pre-edge values; a blocking update would leak into later reads.
      // Commit is OR-ed in after the invalidate clear, so a same-cycle
      // invalidate of the committing way leaves the bit set.
      way_valid_q <= (way_valid_q & ~inv_mask) | commit_mask;

      case (state)
        ST_IDLE: begin
          if (alloc_req_valid) begin
            state   <= ST_PICK;
            ready_q <= 1'b0;
          end
        end

        ST_PICK: begin
          victim_q    <= pick_way;
          gnt_way_q   <= pick_way;
          gnt_valid_q <= 1'b1;
          state       <= ST_FILL;
        end

        ST_FILL: begin
          // Abort takes priority over done when both arrive together.
          if (alloc_abort) begin
            state       <= ST_IDLE;
            gnt_valid_q <= 1'b0;
            gnt_way_q   <= '0;
            ready_q     <= 1'b1;
          end else if (alloc_done) begin
            state       <= ST_COMMIT;
            gnt_valid_q <= 1'b0;
            gnt_way_q   <= '0;
            commit_q    <= 1'b1;
          end
        end

        ST_COMMIT: begin
          state    <= ST_IDLE;
          commit_q <= 1'b0;
          ready_q  <= 1'b1;
        end

        default: begin
          state       <= ST_IDLE;
          gnt_valid_q <= 1'b0;
          gnt_way_q   <= '0;
          commit_q    <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  // LRU touch mux: the commit touch owns the port; hits in that cycle drop.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no
    // latch is inferred.
    lru_wen   = hit_valid;
    lru_waddr = hit_way & {P{hit_valid}};
    if (commit_q) begin
      lru_wen   = 1'b1;
      lru_waddr = victim_q;
    end
  end

  assign alloc_req_ready = ready_q;
  assign alloc_gnt_valid = gnt_valid_q;
  assign alloc_gnt_way   = gnt_way_q;
  assign way_valid       = way_valid_q;
  assign lru_dvalid      = '1;

endmodule

// File: tb/tb_common_pseudo_lru_way_allocator.sv
// Bench for the way allocator with four ways. A behavioural tree-PLRU
// stands in for the pick block; grants are scoreboarded against a queue of
// expected ways, and a vector table drives the main allocation sequence.
`timescale 1ns/1ps

module tb_common_pseudo_lru_way_allocator;

  localparam int P = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         hit_valid;
  logic [P-1:0] hit_way;
  logic         inv_valid;
  logic [P-1:0] inv_way;
  logic         alloc_req_valid;
  logic         alloc_req_ready;
  logic         alloc_gnt_valid;
  logic [P-1:0] alloc_gnt_way;
  logic         alloc_done;
  logic         alloc_abort;
  logic [P-1:0] way_valid;
  logic [P-1:0] lru_waddr;
  logic         lru_wen;
  logic [P-1:0] lru_dvalid;
  logic [P-1:0] lru_qaddr;

  common_pseudo_lru_way_allocator #(.SUBJECT_COUNT_LOG2(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .hit_valid       (hit_valid),
    .hit_way         (hit_way),
    .inv_valid       (inv_valid),
    .inv_way         (inv_way),
    .alloc_req_valid (alloc_req_valid),
    .alloc_req_ready (alloc_req_ready),
    .alloc_gnt_valid (alloc_gnt_valid),
    .alloc_gnt_way   (alloc_gnt_way),
    .alloc_done      (alloc_done),
    .alloc_abort     (alloc_abort),
    .way_valid       (way_valid),
    .lru_waddr       (lru_waddr),
    .lru_wen         (lru_wen),
    .lru_dvalid      (lru_dvalid),
    .lru_qaddr       (lru_qaddr)
  );

  always #5 clk = ~clk;

  // Tree PLRU: root 0 -> left pair, 1 -> right pair; leaf bit selects the
  // upper way of its pair. A touch points every bit on the path away.
  logic plru_root, plru_lft, plru_rgt;

  always @(posedge clk) begin
    if (!reset) begin
      plru_root <= 1'b0;
      plru_lft  <= 1'b0;
      plru_rgt  <= 1'b0;
    end else if (lru_wen) begin
      case (lru_waddr)
        4'b0001: begin plru_root <= 1'b1; plru_lft <= 1'b1; end
        4'b0010: begin plru_root <= 1'b1; plru_lft <= 1'b0; end
        4'b0100: begin plru_root <= 1'b0; plru_rgt <= 1'b1; end
        4'b1000: begin plru_root <= 1'b0; plru_rgt <= 1'b0; end
        default: ;
      endcase
    end
  end

  assign lru_qaddr = plru_root ? (plru_rgt ? 4'b1000 : 4'b0100)
                               : (plru_lft ? 4'b0010 : 4'b0001);

  // Protocol assertions on the touch/invalidate inputs.
  always @(negedge clk) begin
    if (reset && hit_valid)
      assert ($onehot0(hit_way)) else $error("protocol violation: multi-hot hit_way %b", hit_way);
    if (reset && inv_valid)
      assert ($onehot0(inv_way)) else $error("protocol violation: multi-hot inv_way %b", inv_way);
  end

  int n_vec = 0;
  int n_err = 0;
  logic [P-1:0] exp_q [$];
  logic gnt_prev = 1'b0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_way(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Scoreboard: each rising grant is compared with the oldest expected way.
  always @(posedge clk) begin
    #1;
    if (alloc_gnt_valid && !gnt_prev) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL gnt_unexpected: got %b, expected no grant", alloc_gnt_way);
      end else begin
        check_way("gnt_way", alloc_gnt_way, exp_q.pop_front());
      end
    end
    gnt_prev <= alloc_gnt_valid;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Issue one request; the grant is expected exactly two cycles after accept.
  task automatic request(input logic [P-1:0] exp_gnt);
    int t;
    exp_q.push_back(exp_gnt);
    check_bit("req_ready", alloc_req_ready, 1'b1);
    alloc_req_valid = 1'b1;
    tick();
    alloc_req_valid = 1'b0;
    check_bit("pick_no_gnt", alloc_gnt_valid, 1'b0);
    tick();
    t = 0;
    while (!alloc_gnt_valid && t < 8) begin
      tick();
      t++;
    end
    check_way("gnt_latency", 4'(t), 4'd0);
  endtask

  // Finish the fill; check the commit touch and the resulting valid bits.
  task automatic complete(input logic [P-1:0] exp_way, input logic [P-1:0] exp_valid);
    check_way("gnt_hold", alloc_gnt_way, exp_way);
    alloc_done = 1'b1;
    tick();
    alloc_done = 1'b0;
    check_bit("commit_wen", lru_wen, 1'b1);
    check_way("commit_waddr", lru_waddr, exp_way);
    tick();
    check_way("commit_valid", way_valid, exp_valid);
    check_bit("commit_ready", alloc_req_ready, 1'b1);
    check_bit("commit_gnt_low", alloc_gnt_valid, 1'b0);
  endtask

  typedef struct {
    logic         hit_pre;
    logic [P-1:0] hit_way;
    logic         inv_pre;
    logic [P-1:0] inv_way;
    logic [P-1:0] valid_after_inv;
    logic [P-1:0] exp_gnt;
    logic [P-1:0] exp_valid;
  } vec_t;

  vec_t vecs [7];

  task automatic apply_vec(input vec_t v);
    if (v.hit_pre) begin
      hit_valid = 1'b1;
      hit_way   = v.hit_way;
      #1;
      check_bit("hit_fwd_wen", lru_wen, 1'b1);
      check_way("hit_fwd_waddr", lru_waddr, v.hit_way);
      tick();
      hit_valid = 1'b0;
      hit_way   = '0;
    end
    if (v.inv_pre) begin
      inv_valid = 1'b1;
      inv_way   = v.inv_way;
      tick();
      inv_valid = 1'b0;
      inv_way   = '0;
      check_way("inv_clear", way_valid, v.valid_after_inv);
    end
    request(v.exp_gnt);
    complete(v.exp_gnt, v.exp_valid);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // hit_pre, hit_way, inv_pre, inv_way, valid_after_inv, exp_gnt, exp_valid
    vecs[0] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    vecs[1] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0011};
    vecs[2] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0111};
    vecs[3] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1000, 4'b1111};
    vecs[4] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b1111};
    vecs[5] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b1111};
    vecs[6] = '{1'b0, 4'b0000, 1'b1, 4'b0100, 4'b1011, 4'b0100, 4'b1111};

    hit_valid       = 1'b0;
    hit_way         = '0;
    inv_valid       = 1'b0;
    inv_way         = '0;
    alloc_req_valid = 1'b0;
    alloc_done      = 1'b0;
    alloc_abort     = 1'b0;
    do_reset();

    // Reset state.
    check_bit("rst_ready", alloc_req_ready, 1'b1);
    check_bit("rst_gnt_valid", alloc_gnt_valid, 1'b0);
    check_way("rst_gnt_way", alloc_gnt_way, 4'b0000);
    check_way("rst_way_valid", way_valid, 4'b0000);
    check_way("rst_dvalid", lru_dvalid, 4'b1111);
    check_bit("rst_wen", lru_wen, 1'b0);

    // Cold fill, hit-steered LRU victim, invalidate preference.
    for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

    // Hit and invalidate of the victim, both during COMMIT.
    request(4'b0001);
    alloc_done = 1'b1;
    tick();
    alloc_done = 1'b0;
    hit_valid  = 1'b1;
    hit_way    = 4'b0010;
    inv_valid  = 1'b1;
    inv_way    = 4'b0001;
    #1;
    check_bit("commit_hit_wen", lru_wen, 1'b1);
    check_way("commit_hit_drop", lru_waddr, 4'b0001);
    tick();
    hit_valid = 1'b0;
    hit_way   = '0;
    inv_valid = 1'b0;
    inv_way   = '0;
    check_way("commit_beats_inv", way_valid, 4'b1111);

    // Invalidate the victim mid-FILL, then done and abort together.
    request(4'b1000);
    inv_valid = 1'b1;
    inv_way   = 4'b1000;
    tick();
    inv_valid = 1'b0;
    inv_way   = '0;
    check_way("fill_inv_victim", way_valid, 4'b0111);
    check_bit("fill_gnt_held", alloc_gnt_valid, 1'b1);
    alloc_done  = 1'b1;
    alloc_abort = 1'b1;
    tick();
    alloc_done  = 1'b0;
    alloc_abort = 1'b0;
    check_bit("both_abort_ready", alloc_req_ready, 1'b1);
    check_bit("both_abort_gnt", alloc_gnt_valid, 1'b0);
    check_bit("both_abort_wen", lru_wen, 1'b0);
    tick();
    check_way("both_abort_valid", way_valid, 4'b0111);
    request(4'b1000);
    complete(4'b1000, 4'b1111);

    // Fresh cold fill, then the plain LRU victim with a first-cycle abort.
    do_reset();
    for (int i = 0; i < 4; i++) apply_vec(vecs[i]);
    request(4'b0001);
    alloc_abort = 1'b1;
    tick();
    alloc_abort = 1'b0;
    check_bit("abort_ready", alloc_req_ready, 1'b1);
    check_bit("abort_gnt", alloc_gnt_valid, 1'b0);
    check_bit("abort_no_wen", lru_wen, 1'b0);
    check_way("abort_valid", way_valid, 4'b1111);
    tick();
    check_way("abort_valid_later", way_valid, 4'b1111);
    request(4'b0001);
    complete(4'b0001, 4'b1111);

    // Reset while in FILL.
    request(4'b0100);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_bit("midrst_gnt", alloc_gnt_valid, 1'b0);
    check_way("midrst_gnt_way", alloc_gnt_way, 4'b0000);
    check_way("midrst_valid", way_valid, 4'b0000);
    check_bit("midrst_ready", alloc_req_ready, 1'b1);

    tick();
    check_bit("scoreboard_drained", exp_q.size() == 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
